// File: rtl/seq_adder_pkg.sv
// seq_adder_pkg: shared types and constants for the sequential adder tile.
//   state_t     : FSM encoding (idle / running / result ready)
//   uio indices : bit positions of the control inputs and status outputs
//   UIO_OE_VAL  : fixed bidirectional output-enable pattern (status bits out)
package seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // uio_in control bits
  localparam int LOAD_A  = 0;
  localparam int LOAD_B  = 1;
  localparam int START   = 2;
  localparam int SUB     = 3;
  localparam int RD_NEXT = 4;
  // uio_out status bits
  localparam int BUSY    = 5;
  localparam int DONE    = 6;
  localparam int FLAG    = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hE0;

endpackage

// File: rtl/seq_adder_digit.sv
// seq_adder_digit: combinational DIGIT-bit add slice.
//   a, b : operand digits
//   cin  : carry in
//   sum  : digit sum
//   cout : carry out
module seq_adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] total;

  assign total       = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/tt_um_seq_adder.sv
// tt_um_seq_adder: multi-cycle adder/subtractor behind the standard tile ports.
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : design selected; control edges are ignored while low
//   ui_in      : operand byte for load_a / load_b
//   uio_in     : [0] load_a [1] load_b [2] start [3] sub [4] rd_next
//   uo_out     : result byte at the read pointer while done, else 0
//   uio_out    : [5] busy [6] done [7] carry (add) / borrow (sub) while done
//   uio_oe     : constant 8'hE0
// Optional: define SEQ_ADDER_SAT_EN to saturate signed overflow to the
// signed limit instead of wrapping.
//
// Handshake: a rising edge on start (ena high, no load edge in the same
// cycle) while idle or done launches a computation; busy is high for exactly
// WIDTH/DIGIT cycles, then done stays high until the next load or start.
// Loads, starts and rd_next edges seen while busy are dropped.
module tt_um_seq_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int NBYTE = WIDTH / 8;
  localparam int CW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW    = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam logic [WIDTH-1:0] DMASK = WIDTH'((1 << DIGIT) - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    rd_ptr;
  logic             carry, sub_q;
  logic [4:0]       prev;

  logic [4:0]       ev;
  logic             load_ev, start_ev, last_digit;
  logic [WIDTH-1:0] bo, r_wrap, r_next;
  logic [5:0]       off;
  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             c_out;
  logic             unused_ok;

  assign unused_ok = &{1'b0, uio_in[7:5]};

  // Rising-edge events on the control bits, qualified by ena.
  assign ev         = uio_in[4:0] & ~prev & {5{ena}};
  assign load_ev    = ev[LOAD_A] | ev[LOAD_B];
  assign start_ev   = ev[START] & ~load_ev;
  assign last_digit = (cnt == CW'(NDIG - 1));

  // Current digit slice of each operand; subtraction adds ~B with carry-in 1.
  assign bo    = sub_q ? ~op_b : op_b;
  assign off   = 6'(cnt) * 6'(DIGIT);
  assign a_dig = DIGIT'(op_a >> off);
  assign b_dig = DIGIT'(bo >> off);

  seq_adder_digit #(.DIGIT(DIGIT)) u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .cin  (carry),
    .sum  (s_dig),
    .cout (c_out)
  );

  assign r_wrap = (res & ~(DMASK << off)) | (WIDTH'(s_dig) << off);

`ifdef SEQ_ADDER_SAT_EN
  // On the top digit s_dig[DIGIT-1] is the sum msb.
  logic ovf;
  assign ovf    = (op_a[WIDTH-1] == bo[WIDTH-1]) && (s_dig[DIGIT-1] != op_a[WIDTH-1]);
  assign r_next = (last_digit && ovf)
                ? (op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                : r_wrap;
`else
  assign r_next = r_wrap;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start_ev) state_next = ST_RUN;
      ST_RUN:  if (last_digit) state_next = ST_DONE;
      ST_DONE: begin
        if (load_ev)       state_next = ST_IDLE;
        else if (start_ev) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    uo_out  = 8'h00;
    uio_out = 8'h00;
    case (state)
      ST_RUN: uio_out[BUSY] = 1'b1;
      ST_DONE: begin
        uio_out[DONE] = 1'b1;
        uio_out[FLAG] = sub_q ? ~carry : carry;
        uo_out        = 8'(res >> {rd_ptr, 3'b000});
      end
      default: ;
    endcase
  end

  assign uio_oe = UIO_OE_VAL;

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      rd_ptr <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      prev   <= '0;
    end else begin
      prev <= uio_in[4:0];
      if (state == ST_RUN) begin
        res   <= r_next;
        carry <= c_out;
        cnt   <= cnt + CW'(1);
      end else begin
        // Byte shift-in from the top: WIDTH/8 loads fill LSB byte first.
        if (ev[LOAD_A]) op_a <= WIDTH'({ui_in, op_a} >> 8);
        if (ev[LOAD_B]) op_b <= WIDTH'({ui_in, op_b} >> 8);
        if (state == ST_DONE && ev[RD_NEXT])
          rd_ptr <= (rd_ptr == PW'(NBYTE - 1)) ? '0 : rd_ptr + PW'(1);
        if (start_ev) begin
          sub_q  <= uio_in[SUB];
          carry  <= uio_in[SUB];
          cnt    <= '0;
          rd_ptr <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tt_um_seq_adder.sv
module tb_tt_um_seq_adder;

  localparam int W  = 16;
  localparam int D  = 1;
  localparam int NB = W / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out4, uio_out4, uio_oe4;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  tt_um_seq_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  tt_um_seq_adder #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out4),
    .uio_in(uio_in), .uio_out(uio_out4), .uio_oe(uio_oe4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Whole-word arithmetic: the final result is known the moment start is
  // accepted; it only becomes visible after WIDTH/DIGIT clocks.
  logic [W-1:0] m_a = '0, m_b = '0, m_r = '0;
  logic         m_carry = 1'b0, m_sub = 1'b0;
  int           m_phase = 0;   // 0 idle, 1 running, 2 done
  int           m_left = 0;
  int           m_ptr = 0;
  logic [4:0]   m_prev = '0;
  logic [4:0]   m_ev;

  assign m_ev = uio_in[4:0] & ~m_prev & {5{ena}};

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    logic [W-1:0] bo;
    logic [W:0]   full;
    bo   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, sub};
`ifdef SEQ_ADDER_SAT_EN
    if (a[W-1] == bo[W-1] && full[W-1] != a[W-1])
      full[W-1:0] = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return full;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_r <= '0; m_carry <= 1'b0; m_sub <= 1'b0;
      m_phase <= 0; m_left <= 0; m_ptr <= 0; m_prev <= '0;
    end else begin
      m_prev <= uio_in[4:0];
      if (m_phase == 1) begin
        m_left <= m_left - 1;
        if (m_left == 1) m_phase <= 2;
      end else begin
        if (m_ev[0]) m_a <= W'({ui_in, m_a} >> 8);
        if (m_ev[1]) m_b <= W'({ui_in, m_b} >> 8);
        if (m_phase == 2 && m_ev[4]) m_ptr <= (m_ptr + 1) % NB;
        if (m_ev[0] || m_ev[1]) begin
          if (m_phase == 2) m_phase <= 0;
        end else if (m_ev[2]) begin
          {m_carry, m_r} <= ref_sum(m_a, m_b, uio_in[3]);
          m_sub   <= uio_in[3];
          m_phase <= 1;
          m_left  <= W / D;
          m_ptr   <= 0;
        end
      end
    end
  end

  logic [7:0] exp_uo, exp_uio;
  assign exp_uo  = (m_phase == 2) ? 8'(m_r >> (8 * m_ptr)) : 8'h00;
  assign exp_uio = {(m_phase == 2) && (m_sub ? ~m_carry : m_carry),
                    m_phase == 2, m_phase == 1, 5'b00000};

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("uo_out", uo_out, exp_uo);
      check("uio_out", uio_out, exp_uio);
      check("uio_oe", uio_oe, 8'hE0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic pulse(input logic [7:0] bits, input logic [7:0] data);
    @(posedge clk); #2;
    uio_in = bits;
    ui_in  = data;
    @(posedge clk); #2;
    uio_in = 8'h00;
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b);
    pulse(8'h01, a[7:0]);
    pulse(8'h01, a[15:8]);
    pulse(8'h02, b[7:0]);
    pulse(8'h02, b[15:8]);
  endtask

  // Counts clocks after the start edge until done; -1 on timeout.
  task automatic wait_done(output int lat, output int lat4);
    lat  = -1;
    lat4 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (uio_out4[6] && lat4 < 0) lat4 = k;
      if (uio_out[6]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_op(input logic sub, output int lat, output int lat4);
    pulse(sub ? 8'h0C : 8'h04, 8'h00);
    wait_done(lat, lat4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, lat4;
    check_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo", uo_out, 8'h00);
    check("reset_uio", uio_out, 8'h00);
    check("reset_oe", uio_oe, 8'hE0);
    @(negedge clk) rst_n = 1'b1;

    // load_a and start in the same cycle: load wins, stays idle
    pulse(8'h05, 8'hAB);
    tick();
    check("load_start_idle", uio_out, 8'h00);

    // 0x1234 + 0x0FCD = 0x2201
    load_ops(16'h1234, 16'h0FCD);
    run_op(1'b0, lat, lat4);
    check("lat_d1", lat, 16);
    check("lat_d4", lat4, 4);
    check("model_r", m_r, 16'h2201);
    check("t1_byte0", uo_out, 8'h01);
    check("t1_flag", uio_out[7], 1'b0);
    check("d4_byte0", uo_out4, 8'h01);
    pulse(8'h10, 8'h00);
    check("rd_ptr1", uo_out, 8'h22);
    pulse(8'h10, 8'h00);
    check("rd_ptr0", uo_out, 8'h01);
    pulse(8'h10, 8'h00);
    check("rd_ptr1b", uo_out, 8'h22);
    ena = 1'b0;
    pulse(8'h10, 8'h00);
    ena = 1'b1;
    tick();
    check("rd_ena_low", uo_out, 8'h22);

    // 0xFFFF + 0x0001 = 0x0000 carry 1
    load_ops(16'hFFFF, 16'h0001);
    run_op(1'b0, lat, lat4);
    check("wrap_lo", uo_out, 8'h00);
    check("wrap_flag", uio_out[7], 1'b1);

    // 0x0005 - 0x0007 = 0xFFFE borrow 1
    load_ops(16'h0005, 16'h0007);
    run_op(1'b1, lat, lat4);
    check("sub_lo", uo_out, 8'hFE);
    check("sub_borrow", uio_out[7], 1'b1);
    pulse(8'h10, 8'h00);
    check("sub_hi", uo_out, 8'hFF);

    // 0x7FFF + 0x0001: signed overflow
    load_ops(16'h7FFF, 16'h0001);
    run_op(1'b0, lat, lat4);
`ifdef SEQ_ADDER_SAT_EN
    check("ovf_lo", uo_out, 8'hFF);
    pulse(8'h10, 8'h00);
    check("ovf_hi", uo_out, 8'h7F);
`else
    check("ovf_lo", uo_out, 8'h00);
    pulse(8'h10, 8'h00);
    check("ovf_hi", uo_out, 8'h80);
`endif
    check("ovf_flag", uio_out[7], 1'b0);

    // edges during RUN are ignored
    load_ops(16'h0010, 16'h0020);
    pulse(8'h04, 8'h00);
    tick();
    check("run_busy", uio_out[5], 1'b1);
    check("run_uo_zero", uo_out, 8'h00);
    pulse(8'h05, 8'hEE);
    wait_done(lat, lat4);
    check("run_ign_lat", lat, 16 - 3);
    check("run_ign_lo", uo_out, 8'h30);
    run_op(1'b0, lat, lat4);
    check("recompute_lo", uo_out, 8'h30);
    pulse(8'h10, 8'h00);
    check("recompute_hi", uo_out, 8'h00);

    // reset mid-RUN
    load_ops(16'h1111, 16'h2222);
    pulse(8'h04, 8'h00);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_uio", uio_out, 8'h00);
    check("rst_mid_uo", uo_out, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    load_ops(16'h1234, 16'h1111);
    run_op(1'b0, lat, lat4);
    check("after_rst_lo", uo_out, 8'h45);
    pulse(8'h10, 8'h00);
    check("after_rst_hi", uo_out, 8'h23);

    // randomized stimulus against the model
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #2;
      ena    = ($urandom_range(0, 9) != 0);
      ui_in  = 8'($urandom_range(0, 255));
      uio_in = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
    end
    uio_in = 8'h00;
    ena    = 1'b1;
    repeat (40) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
